// File: rtl/alu_seq.sv
// Clocked add/sub/accumulate unit with an iterative shift-add multiplier.
// Registered result and flags with a busy/done handshake; disabled drives all ones.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic             i_acc_clr,
   input  logic [WIDTH-1:0] i_input_a,
   input  logic [WIDTH-1:0] i_input_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_busy,
   output logic             o_done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_ovf;
   logic               r_zero;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_acc_base;
   logic [WIDTH:0]     w_acc_sum;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic               w_add_ovf;
   logic               w_sub_ovf;
   logic               w_acc_ovf;

   assign w_accept   = i_en && i_start && (r_state == S_IDLE);
   assign w_last     = (r_state == S_MUL) && (r_cnt == CW'(1));
   assign w_sum      = {1'b0, i_input_a} + {1'b0, i_input_b};
   assign w_diff     = {1'b0, i_input_a} - {1'b0, i_input_b};
   // A clear in the same edge as an accumulate is applied first.
   assign w_acc_base = i_acc_clr ? '0 : r_acc;
   assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, i_input_a};
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

   assign w_add_ovf = (i_input_a[WIDTH-1] == i_input_b[WIDTH-1])
                   && (w_sum[WIDTH-1] != i_input_a[WIDTH-1]);
   assign w_sub_ovf = (i_input_a[WIDTH-1] != i_input_b[WIDTH-1])
                   && (w_diff[WIDTH-1] != i_input_a[WIDTH-1]);
   assign w_acc_ovf = (w_acc_base[WIDTH-1] == i_input_a[WIDTH-1])
                   && (w_acc_sum[WIDTH-1] != i_input_a[WIDTH-1]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_en) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_accept && i_op == 2'b10) w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_acc_clr) r_acc <= '0;
         if (!i_en) begin
            r_result <= '1;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
         end else if (w_accept) begin
            unique case (i_op)
               2'b00: begin
                  r_result <= w_sum[WIDTH-1:0];
                  r_carry  <= w_sum[WIDTH];
                  r_ovf    <= w_add_ovf;
                  r_zero   <= (w_sum[WIDTH-1:0] == '0);
                  r_done   <= 1'b1;
               end
               2'b01: begin
                  r_result <= w_diff[WIDTH-1:0];
                  r_carry  <= w_diff[WIDTH];
                  r_ovf    <= w_sub_ovf;
                  r_zero   <= (w_diff[WIDTH-1:0] == '0);
                  r_done   <= 1'b1;
               end
               2'b10: begin
                  r_mcand  <= {{WIDTH{1'b0}}, i_input_a};
                  r_mplier <= i_input_b;
                  r_prod   <= '0;
                  r_cnt    <= CW'(WIDTH);
                  r_busy   <= 1'b1;
               end
               2'b11: begin
                  r_acc    <= w_acc_sum[WIDTH-1:0];
                  r_result <= w_acc_sum[WIDTH-1:0];
                  r_carry  <= w_acc_sum[WIDTH];
                  r_ovf    <= w_acc_ovf;
                  r_zero   <= (w_acc_sum[WIDTH-1:0] == '0);
                  r_done   <= 1'b1;
               end
               default: ;
            endcase
         end else if (r_state == S_MUL) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (w_last) begin
               r_result <= w_prod_nxt[WIDTH-1:0];
               r_ovf    <= |w_prod_nxt[2*WIDTH-1:WIDTH];
               r_carry  <= 1'b0;
               r_zero   <= (w_prod_nxt[WIDTH-1:0] == '0);
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign o_result = r_result;
   assign o_carry  = r_carry;
   assign o_ovf    = r_ovf;
   assign o_zero   = r_zero;
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic model.
// Model computes results with plain integer math from the operation rules.
module tb_alu_seq;
   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         start;
   logic [1:0]   op;
   logic         acc_clr;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         carry;
   logic         ovf;
   logic         zero;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;
   int m_acc    = 0;

   alu_seq #(.WIDTH(W)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (en),
      .i_start   (start),
      .i_op      (op),
      .i_acc_clr (acc_clr),
      .i_input_a (a),
      .i_input_b (b),
      .o_result  (result),
      .o_carry   (carry),
      .o_ovf     (ovf),
      .o_zero    (zero),
      .o_busy    (busy),
      .o_done    (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= M / 2) ? x - M : x;
   endfunction

   function automatic int out_rng(input int s);
      return (s > M / 2 - 1 || s < -(M / 2)) ? 1 : 0;
   endfunction

   task automatic do_alu(input int o, input int va, input int vb,
                         input int clr);
      int s, res, c, v;
      if (clr != 0) m_acc = 0;
      if (o == 0) begin
         s = va + vb; res = s % M; c = (s >= M);
         v = out_rng(sgn(va) + sgn(vb));
      end else if (o == 1) begin
         res = (va - vb + M) % M; c = (va < vb);
         v = out_rng(sgn(va) - sgn(vb));
      end else begin
         s = m_acc + va; res = s % M; c = (s >= M);
         v = out_rng(sgn(m_acc) + sgn(va));
         m_acc = res;
      end
      op = 2'(o); a = W'(va); b = W'(vb);
      acc_clr = (clr != 0); start = 1'b1;
      step();
      start = 1'b0; acc_clr = 1'b0;
      chk("alu_result", int'(result), res);
      chk("alu_carry", int'(carry), c);
      chk("alu_ovf", int'(ovf), v);
      chk("alu_zero", int'(zero), int'(res == 0));
      chk("alu_done", int'(done), 1);
      chk("alu_busy", int'(busy), 0);
      step();
      chk("alu_done_drop", int'(done), 0);
   endtask

   task automatic do_mul(input int va, input int vb, input int clr,
                         input int inject);
      int p, n, nb, res;
      p = va * vb; res = p % M;
      if (clr != 0) m_acc = 0;
      op = 2'b10; a = W'(va); b = W'(vb);
      acc_clr = (clr != 0); start = 1'b1;
      step();
      start = 1'b0; acc_clr = 1'b0;
      chk("mul_busy_start", int'(busy), 1);
      chk("mul_done_start", int'(done), 0);
      if (inject != 0) begin
         op = 2'b00; a = 1; b = 1; start = 1'b1;
      end
      n = 1; nb = 1;
      while (!done && n < 4 * W) begin
         step();
         start = 1'b0;
         n++;
         if (busy) nb++;
      end
      chk("mul_latency", n, W + 1);
      chk("mul_busy_cycles", nb, W);
      chk("mul_result", int'(result), res);
      chk("mul_ovf", int'(ovf), int'(p >= M));
      chk("mul_carry", int'(carry), 0);
      chk("mul_zero", int'(zero), int'(res == 0));
      step();
      chk("mul_done_drop", int'(done), 0);
      chk("mul_result_hold", int'(result), res);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0; op = 2'b00;
      acc_clr = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_result", int'(result), 0);
      chk("rst_zero", int'(zero), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b0; en = 1'b1;
      step();

      do_alu(0, 7, 9, 0);
      do_alu(0, 7, 1, 0);
      do_alu(1, 3, 5, 0);
      do_alu(1, 8, 1, 0);
      do_mul(5, 3, 0, 0);
      do_mul(5, 4, 0, 1);

      acc_clr = 1'b1; step(); acc_clr = 1'b0; m_acc = 0;
      chk("clr_no_done", int'(done), 0);
      for (int i = 0; i < 4; i++) do_alu(3, 6, 0, 0);
      do_alu(3, 3, 0, 1);

      op = 2'b10; a = 7; b = 2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("en_busy_before", int'(busy), 1);
      en = 1'b0;
      step();
      chk("dis_result", int'(result), M - 1);
      chk("dis_busy", int'(busy), 0);
      chk("dis_done", int'(done), 0);
      chk("dis_zero", int'(zero), 0);
      chk("dis_carry", int'(carry), 0);
      chk("dis_ovf", int'(ovf), 0);
      en = 1'b1;
      for (int i = 0; i < W + 1; i++) begin
         step();
         chk("reen_no_done", int'(done), 0);
      end
      chk("reen_hold", int'(result), M - 1);
      do_alu(3, 1, 0, 0);

      op = 2'b10; a = 5; b = 3; start = 1'b1;
      step();
      start = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("mrst_result", int'(result), 0);
      chk("mrst_zero", int'(zero), 1);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(done), 0);
      rst = 1'b0; m_acc = 0;
      for (int i = 0; i < W + 1; i++) begin
         step();
         chk("mrst_no_done", int'(done), 0);
      end
      do_alu(0, 2, 3, 0);
      do_alu(3, 1, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int ro, ra, rb, rc;
         ro = int'($urandom_range(0, 3));
         ra = int'($urandom_range(0, M - 1));
         rb = int'($urandom_range(0, M - 1));
         rc = ($urandom_range(0, 7) == 0) ? 1 : 0;
         if (ro == 2) do_mul(ra, rb, rc, int'($urandom_range(0, 1)));
         else do_alu(ro, ra, rb, rc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the lab-one add/subtract selector. It accepts a start request with two WIDTH-bit operands and performs add, subtract, iterative shift-add multiply or accumulate. Results and status flags are registered, with a busy/done handshake. It sits between the board switch/button front end and the LED/segment display path, and keeps the established convention that a disabled unit drives an all-ones result.

## Interface
- WIDTH, 4, operand/result width in bits; must be ≥ 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  unit enable; low aborts any operation and forces the disabled output.
- start  in  1  request; sampled only in IDLE with en=1.
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 accumulate.
- acc_clr  in  1  synchronous accumulator clear.
- input_a  in  WIDTH  operand A (accumulate addend).
- input_b  in  WIDTH  operand B (ignored for op 11).
- result  out  WIDTH  registered result.
- carry  out  1  add/acc carry-out; sub borrow; 0 for mul.
- ovf  out  1  signed overflow for add/sub/acc; high half ≠ 0 for mul.
- zero  out  1  result == 0 (0 while disabled).
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when result/flags update from an operation.

## Operation
- FSM states: IDLE and MUL.
- IDLE: start=1 and en=1 at an edge launches op. For op 00/01/11, result and flags are written at that edge and done=1 for the following cycle; the FSM stays in IDLE. For op 10, operands are latched, the counter is loaded with WIDTH, and the FSM enters MUL with busy=1.
- MUL: each edge performs one shift-add step and decrements the counter. The edge that takes the counter to 0 writes result = low WIDTH bits of a*b (unsigned) and ovf = (high WIDTH bits ≠ 0). The same edge sets carry=0, updates zero, sets busy=0 and done=1, and returns to IDLE.
- Add: result = (a+b) mod 2^WIDTH. carry = bit WIDTH of the sum. ovf = operands have the same sign and the result sign differs.
- Sub: result = (a−b) mod 2^WIDTH. carry = borrow (a < b unsigned). ovf = operand signs differ and the result sign differs from a.
- Accumulate: acc ← acc + a with wrap. result = new acc. carry and ovf follow the add rules, computed on acc and a.
- The accumulator is internal, WIDTH bits, and is changed only by op 11, acc_clr and rst.
- acc_clr: acc ← 0 at the edge, whether or not the unit is busy. If an op-11 start is accepted at the same edge, the clear applies first, so acc ← a and result = a.
- start while busy, or in any state other than IDLE, is ignored without queueing. op and operands are sampled only at acceptance.
- en=0 at any edge: the FSM goes to IDLE, busy=0, done=0, result = all ones, and carry/ovf/zero = 0. An in-flight multiply is discarded. acc is retained. acc_clr still acts while disabled.
- When en returns high, result holds all ones until the next completed operation.

## Timing
- Reset values (asynchronous, immediate): result=0, acc=0, carry=0, ovf=0, zero=1, busy=0, done=0, state IDLE.
- add/sub/acc latency is 1 edge. The FSM is back-to-back capable: start may be held high to issue every cycle.
- mul latency is WIDTH+1 edges from acceptance to the done edge. busy is high for exactly WIDTH cycles.
- done is never high for two consecutive cycles from a single operation.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-multiply clears everything immediately; no done is produced.

## Test plan (WIDTH=4)
- add: a=7, b=9 → result 0000, carry 1, zero 1, ovf 0, done pulse 1 cycle after the start edge. Then a=7, b=1 → 1000, ovf 1.
- sub: a=3, b=5 → 1110, carry 1, ovf 0. Then a=1000, b=0001 → 0111, ovf 1.
- mul: 5×3 → result 1111, ovf 0, busy high 4 cycles, done at the 5th edge. Then 5×4 → 0100, ovf 1. A start with op 00 during busy has no effect.
- accumulate: acc_clr, then four op-11 starts with a=6 → results 0110, 1100, 0010 (carry 1), 1000. Then acc_clr and an op-11 start with a=3 at the same edge → 0011.
- en drops at the 2nd busy cycle of 7×2 → next edge result 1111, busy 0, no done. Re-enable and run acc with a=1 → previous acc+1.
- rst pulse between edges during a multiply → outputs take reset values immediately; the next start behaves as from power-up.
